// File: rtl/acc_alu.sv
// acc_alu: accumulator ALU with single-cycle immediate ops and an optional
// shift-add MULI, built only when ACC_ALU_MUL_EN is defined.
module acc_alu #(
  parameter int WIDTH = 8,
  parameter int IMM_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [2:0]       op_code,
  input  logic [IMM_W-1:0] imm,
  output logic [WIDTH-1:0] ac_out,
  output logic             res_valid,
  output logic             zero,
  output logic             carry,
  output logic             err
);
  localparam logic [2:0] ADDI = 3'd0, PASS = 3'd1, SUBI = 3'd2, ANDI = 3'd3;
  localparam logic [2:0] ORI = 3'd4, LOADI = 3'd5, MULI = 3'd6;
`ifdef ACC_ALU_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif
  logic [WIDTH-1:0] imm_x, nx_ac, mul_p, wr_ac;
  logic [WIDTH:0]   sum, dif;
  logic             nx_c, nx_err, accept, is_mul, commit_mul, mul_c, wr;
  assign imm_x  = WIDTH'(imm);
  assign accept = op_valid & op_ready;
  assign is_mul = MUL_EN && op_code == MULI;
  assign sum    = {1'b0, ac_out} + {1'b0, imm_x};
  assign dif    = {1'b0, ac_out} - {1'b0, imm_x};
  always_comb begin
    nx_ac  = ac_out;
    nx_c   = 1'b0;
    nx_err = 1'b0;
    case (op_code)
      ADDI:    {nx_c, nx_ac} = sum;
      PASS:    nx_c = carry;
      SUBI:    {nx_c, nx_ac} = dif;
      ANDI:    nx_ac = ac_out & imm_x;
      ORI:     nx_ac = ac_out | imm_x;
      LOADI:   nx_ac = imm_x;
      MULI:    begin nx_c = carry; nx_err = !MUL_EN; end
      default: nx_ac = '0;
    endcase
  end
`ifdef ACC_ALU_MUL_EN
  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
  localparam int PW = WIDTH + IMM_W;
  localparam int CW = $clog2(IMM_W + 1);
  state_t           state, state_nx;
  logic [PW-1:0]    mcand, prod, prod_nx;
  logic [IMM_W-1:0] mplier;
  logic [CW-1:0]    cnt;
  logic             last;
  assign last       = cnt == CW'(IMM_W - 1);
  assign prod_nx    = prod + (mplier[0] ? mcand : '0);
  assign op_ready   = state != MUL;
  assign commit_mul = state == MUL && last;
  assign mul_p      = prod_nx[WIDTH-1:0];
  assign mul_c      = |prod_nx[PW-1:WIDTH];
  // DONE already holds the committed product, so it accepts like IDLE
  always_comb begin
    state_nx = state;
    case (state)
      MUL:     state_nx = last ? DONE : MUL;
      default: state_nx = accept && is_mul ? MUL : IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state  <= IDLE;
      mcand  <= '0;
      prod   <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else begin
      state <= state_nx;
      if (accept && is_mul) begin
        mcand  <= PW'(ac_out);
        mplier <= imm;
        prod   <= '0;
        cnt    <= '0;
      end else if (state == MUL) begin
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        prod   <= prod_nx;
        cnt    <= cnt + CW'(1);
      end
    end
`else
  assign op_ready   = 1'b1;
  assign commit_mul = 1'b0;
  assign mul_p      = '0;
  assign mul_c      = 1'b0;
`endif
  assign wr    = (accept && !is_mul) || commit_mul;
  assign wr_ac = commit_mul ? mul_p : nx_ac;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ac_out    <= '0;
      zero      <= 1'b1;
      carry     <= 1'b0;
      err       <= 1'b0;
      res_valid <= 1'b0;
    end else begin
      res_valid <= wr;
      if (accept) err <= nx_err;
      if (wr) begin
        ac_out <= wr_ac;
        zero   <= wr_ac == '0;
        carry  <= commit_mul ? mul_c : nx_c;
      end
    end
endmodule

// File: tb/tb_acc_alu.sv
// tb_acc_alu: directed table, corner sequences and random ops against an
// arithmetic reference model; MULI checks follow ACC_ALU_MUL_EN.
module tb_acc_alu;
  localparam int W = 8;
  localparam int IW = 6;
  localparam int MASK = (1 << W) - 1;
  localparam logic [2:0] ADDI = 3'd0, PASS = 3'd1, SUBI = 3'd2, ANDI = 3'd3;
  localparam logic [2:0] ORI = 3'd4, LOADI = 3'd5, MULI = 3'd6, CLR = 3'd7;

  logic clk = 0, rst = 0, op_valid = 0;
  logic op_ready, res_valid, zero, carry, err;
  logic [2:0] op_code = '0;
  logic [IW-1:0] imm = '0;
  logic [W-1:0] ac_out;

  acc_alu #(.WIDTH(W), .IMM_W(IW)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready),
    .op_code(op_code), .imm(imm), .ac_out(ac_out), .res_valid(res_valid),
    .zero(zero), .carry(carry), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int m_ac = 0;
  bit m_c = 0, m_err = 0;

  typedef struct {
    logic [2:0]    op;
    logic [IW-1:0] im;
    logic [W-1:0]  ac;
    logic          c;
    logic          z;
  } vec_t;
  vec_t tbl[15];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic ref_step(input logic [2:0] op, input logic [IW-1:0] im);
    int p;
    int v;
    v = int'(im);
    m_err = 0;
    case (op)
      ADDI:  begin p = m_ac + v; m_c = p > MASK; m_ac = p & MASK; end
      PASS:  ;
      SUBI:  begin m_c = v > m_ac; m_ac = (m_ac - v) & MASK; end
      ANDI:  begin m_ac = m_ac & v; m_c = 0; end
      ORI:   begin m_ac = m_ac | v; m_c = 0; end
      LOADI: begin m_ac = v; m_c = 0; end
      MULI: begin
`ifdef ACC_ALU_MUL_EN
        p = m_ac * v; m_c = p > MASK; m_ac = p & MASK;
`else
        m_err = 1;
`endif
      end
      default: begin m_ac = 0; m_c = 0; end
    endcase
  endtask

  task automatic model_check(input string tag);
    chk({tag, "_ac"}, ac_out, m_ac);
    chk({tag, "_carry"}, carry, m_c);
    chk({tag, "_zero"}, zero, m_ac == 0);
    chk({tag, "_err"}, err, m_err);
  endtask

  task automatic run_op(input logic [2:0] op, input logic [IW-1:0] im);
    int n;
    logic rdy;
    op_valid = 1; op_code = op; imm = im; n = 0;
    do begin
      rdy = op_ready;
      @(posedge clk); #1;
      n++;
    end while (!rdy && n < 30);
    chk("accept", rdy, 1);
    op_valid = 0;
    n = 0;
    while (!res_valid && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    chk("res_valid", res_valid, 1);
    ref_step(op, im);
    model_check("op");
  endtask

  task automatic pulse_reset;
    #2 rst = 1;
    #1;
    chk("rst_ac", ac_out, 0);
    chk("rst_zero", zero, 1);
    chk("rst_carry", carry, 0);
    chk("rst_err", err, 0);
    chk("rst_ready", op_ready, 1);
    chk("rst_rv", res_valid, 0);
    #2 rst = 0;
    m_ac = 0; m_c = 0; m_err = 0;
  endtask

  initial begin
    int rv;
    int low;
    bit hold_ok;
    int n;
    tbl[0]  = '{LOADI, 6'h3F, 8'h3F, 1'b0, 1'b0};
    tbl[1]  = '{ADDI,  6'h3F, 8'h7E, 1'b0, 1'b0};
    tbl[2]  = '{CLR,   6'h00, 8'h00, 1'b0, 1'b1};
    tbl[3]  = '{SUBI,  6'h10, 8'hF0, 1'b1, 1'b0};
    tbl[4]  = '{ADDI,  6'h20, 8'h10, 1'b1, 1'b0};
    tbl[5]  = '{SUBI,  6'h11, 8'hFF, 1'b1, 1'b0};
    tbl[6]  = '{PASS,  6'h00, 8'hFF, 1'b1, 1'b0};
    tbl[7]  = '{ANDI,  6'h0F, 8'h0F, 1'b0, 1'b0};
    tbl[8]  = '{ORI,   6'h30, 8'h3F, 1'b0, 1'b0};
    tbl[9]  = '{ADDI,  6'h01, 8'h40, 1'b0, 1'b0};
    tbl[10] = '{SUBI,  6'h3F, 8'h01, 1'b0, 1'b0};
    tbl[11] = '{SUBI,  6'h01, 8'h00, 1'b0, 1'b1};
    tbl[12] = '{PASS,  6'h2A, 8'h00, 1'b0, 1'b1};
    tbl[13] = '{ADDI,  6'h00, 8'h00, 1'b0, 1'b1};
    tbl[14] = '{ORI,   6'h2A, 8'h2A, 1'b0, 1'b0};

    #1 rst = 1;
    #1;
    chk("reset_ac", ac_out, 0);
    chk("reset_zero", zero, 1);
    chk("reset_carry", carry, 0);
    chk("reset_err", err, 0);
    chk("reset_rv", res_valid, 0);
    chk("reset_ready", op_ready, 1);
    #10 rst = 0;

    // back-to-back single-cycle ops, one per clock
    op_valid = 1;
    for (int i = 0; i < 15; i++) begin
      op_code = tbl[i].op;
      imm = tbl[i].im;
      chk("tbl_ready", op_ready, 1);
      @(posedge clk); #1;
      chk("tbl_rv", res_valid, 1);
      chk("tbl_ac", ac_out, tbl[i].ac);
      chk("tbl_carry", carry, tbl[i].c);
      chk("tbl_zero", zero, tbl[i].z);
      chk("tbl_err", err, 0);
    end
    op_valid = 0;
    @(posedge clk); #1;
    chk("idle_rv", res_valid, 0);
    chk("idle_ac", ac_out, 8'h2A);

    run_op(CLR, 6'h00);

`ifdef ACC_ALU_MUL_EN
    run_op(LOADI, 6'h12);
    op_valid = 1; op_code = MULI; imm = 6'h0D;
    chk("mul_ready", op_ready, 1);
    @(posedge clk); #1;
    op_code = ADDI; imm = 6'h01;
    low = 0; rv = 0; hold_ok = 1; n = 0;
    while (!op_ready && n < 20) begin
      low++;
      if (ac_out !== 8'h12) hold_ok = 0;
      if (res_valid) rv++;
      @(posedge clk); #1;
      n++;
    end
    chk("mul_busy_cycles", low, 6);
    chk("mul_hold_ac", hold_ok, 1);
    chk("mul_early_rv", rv, 0);
    chk("mul_rv", res_valid, 1);
    chk("mul_ac", ac_out, 8'hEA);
    chk("mul_carry", carry, 0);
    chk("mul_zero", zero, 0);
    @(posedge clk); #1;
    op_valid = 0;
    chk("held_rv", res_valid, 1);
    chk("held_ac", ac_out, 8'hEB);
    ref_step(MULI, 6'h0D);
    ref_step(ADDI, 6'h01);
    @(posedge clk); #1;
    chk("held_once", res_valid, 0);
    model_check("held");

    run_op(LOADI, 6'h20);
    run_op(ADDI, 6'h20);
    run_op(MULI, 6'h08);
    chk("mulovf_ac", ac_out, 0);
    chk("mulovf_carry", carry, 1);
    chk("mulovf_zero", zero, 1);

    // reset lands in the third MUL cycle
    run_op(LOADI, 6'h12);
    op_valid = 1; op_code = MULI; imm = 6'h0D;
    @(posedge clk); #1;
    op_valid = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    pulse_reset();
    rv = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (res_valid) rv++;
    end
    chk("abort_no_rv", rv, 0);
    chk("abort_ac", ac_out, 0);
`else
    run_op(LOADI, 6'h07);
    run_op(MULI, 6'h05);
    chk("nomul_ac", ac_out, 8'h07);
    chk("nomul_err", err, 1);
    run_op(ADDI, 6'h01);
    chk("nomul_next_ac", ac_out, 8'h08);
    chk("nomul_next_err", err, 0);

    run_op(LOADI, 6'h3F);
    run_op(ADDI, 6'h3F);
    run_op(SUBI, 6'h3F);
    pulse_reset();
    @(posedge clk); #1;
    chk("rst_no_rv", res_valid, 0);
`endif

    // first edge after reset release accepts an op
    rst = 1;
    #2 rst = 0;
    m_ac = 0; m_c = 0; m_err = 0;
    op_valid = 1; op_code = LOADI; imm = 6'h15;
    @(posedge clk); #1;
    op_valid = 0;
    chk("post_rst_rv", res_valid, 1);
    chk("post_rst_ac", ac_out, 8'h15);
    ref_step(LOADI, 6'h15);

    for (int i = 0; i < 300; i++) begin
      run_op(3'($urandom_range(0, 7)), IW'($urandom_range(0, 63)));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
        chk("rand_idle_rv", res_valid, 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
